// File: rtl/cpu_control_if.sv
// Control/flag bundle between the microcode sequencer (master) and the datapath (slave).
interface cpu_control_if;
    logic [3:0] OPCODE;
    logic       CF;
    logic       ZF;
    logic       HLT;
    logic       MI;
    logic       RI;
    logic       RO;
    logic       II;
    logic       IO;
    logic       AI;
    logic       AO;
    logic       EO;
    logic       SU;
    logic       FIn;
    logic       BI;
    logic       OI;
    logic       CE;
    logic       CO;
    logic       J;
    logic [2:0] STEP;

    modport master (
        input  OPCODE, CF, ZF,
        output HLT, MI, RI, RO, II, IO, AI, AO, EO, SU, FIn, BI, OI, CE, CO, J, STEP
    );

    modport slave (
        output OPCODE, CF, ZF,
        input  HLT, MI, RI, RO, II, IO, AI, AO, EO, SU, FIn, BI, OI, CE, CO, J, STEP
    );
endinterface

// File: rtl/cpu_control.sv
// Microcode sequencer for the 8-bit CPU: T-state counter, opcode decode, bus control lines.
// Optional CTRL_EARLY_END_EN: each instruction ends after its last non-empty step.
module cpu_control #(
    parameter int unsigned NSTEPS = 5
) (
    input  logic         CLK,
    input  logic         RESETn,
    cpu_control_if.master bus
);

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam logic [2:0] LastStep = 3'(NSTEPS - 1);

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic       instr_done;

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

`ifdef CTRL_EARLY_END_EN
    logic [2:0] op_last;

    // Last non-empty step per opcode; conditional jumps end at T2 whether taken or not
    always_comb begin
        op_last = 3'd1;
        case (bus.OPCODE)
            OpLda, OpSta:                        op_last = 3'd3;
            OpAdd, OpSub:                        op_last = 3'd4;
            OpLdi, OpJmp, OpJc, OpJz, OpOut,
            OpHlt:                               op_last = 3'd2;
            default:                             op_last = 3'd1;
        endcase
    end

    assign instr_done = (step_q == LastStep) || (step_q == op_last);
`else
    assign instr_done = (step_q == LastStep);
`endif

    // Next-state logic
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            // Halting freezes the counter at T2
            if (step_q == 3'd2 && bus.OPCODE == OpHlt) begin
                halted_d = 1'b1;
            end else begin
                step_d = instr_done ? 3'd0 : step_q + 3'd1;
            end
        end
    end

    // Output decode
    always_comb begin
        bus.HLT  = 1'b0;
        bus.MI   = 1'b0;
        bus.RI   = 1'b0;
        bus.RO   = 1'b0;
        bus.II   = 1'b0;
        bus.IO   = 1'b0;
        bus.AI   = 1'b0;
        bus.AO   = 1'b0;
        bus.EO   = 1'b0;
        bus.SU   = 1'b0;
        bus.FIn  = 1'b1;
        bus.BI   = 1'b0;
        bus.OI   = 1'b0;
        bus.CE   = 1'b0;
        bus.CO   = 1'b0;
        bus.J    = 1'b0;
        bus.STEP = RESETn ? step_q : 3'd0;

        if (RESETn) begin
            if (halted_q) begin
                bus.HLT = 1'b1;
            end else begin
                case (step_q)
                    3'd0: begin
                        bus.CO = 1'b1;
                        bus.MI = 1'b1;
                    end
                    3'd1: begin
                        bus.RO = 1'b1;
                        bus.II = 1'b1;
                        bus.CE = 1'b1;
                    end
                    3'd2: begin
                        case (bus.OPCODE)
                            OpLda, OpAdd, OpSub, OpSta: begin
                                bus.IO = 1'b1;
                                bus.MI = 1'b1;
                            end
                            OpLdi: begin
                                bus.IO = 1'b1;
                                bus.AI = 1'b1;
                            end
                            OpJmp: begin
                                bus.IO = 1'b1;
                                bus.J  = 1'b1;
                            end
                            // Flags are sampled live so a T4 flag update is already visible
                            OpJc: begin
                                bus.IO = 1'b1;
                                bus.J  = bus.CF;
                            end
                            OpJz: begin
                                bus.IO = 1'b1;
                                bus.J  = bus.ZF;
                            end
                            OpOut: begin
                                bus.AO = 1'b1;
                                bus.OI = 1'b1;
                            end
                            OpHlt:   bus.HLT = 1'b1;
                            default: ;
                        endcase
                    end
                    3'd3: begin
                        case (bus.OPCODE)
                            OpLda: begin
                                bus.RO = 1'b1;
                                bus.AI = 1'b1;
                            end
                            OpAdd, OpSub: begin
                                bus.RO = 1'b1;
                                bus.BI = 1'b1;
                            end
                            OpSta: begin
                                bus.AO = 1'b1;
                                bus.RI = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        if (bus.OPCODE == OpAdd || bus.OPCODE == OpSub) begin
                            bus.EO  = 1'b1;
                            bus.AI  = 1'b1;
                            bus.FIn = 1'b0;
                            bus.SU  = (bus.OPCODE == OpSub);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single bus driver per step
    a_one_driver: assert property (@(posedge CLK)
        $onehot0({bus.RO, bus.IO, bus.AO, bus.EO, bus.CO}));

    logic unused_nop;
    assign unused_nop = (OpNop == 4'h0);

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: table-driven microcode model, directed cases then random.
module tb_cpu_control;

    localparam int unsigned NSTEPS = 5;
`ifdef CTRL_EARLY_END_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    // Bit positions of the packed control word
    localparam int BHlt = 15, BMi = 14, BRi = 13, BRo = 12, BIi = 11, BIo = 10, BAi = 9;
    localparam int BAo = 8, BEo = 7, BSu = 6, BFin = 5, BBi = 4, BOi = 3, BCe = 2, BCo = 1;
    localparam int BJ = 0;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [2:0]  step;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    cpu_control_if bus ();

    cpu_control #(.NSTEPS(NSTEPS)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    // Active-high microcode table; FIn polarity is applied when building expectations
    logic [15:0] ucode [16][8];
    int          last_step [16];
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;
    bit          done = 1'b0;

    int          mstep = 0;
    bit          mhalt = 1'b0;
    logic        cur_rst = 1'b0;
    logic [3:0]  cur_op = 4'h0;
    logic        cur_cf = 1'b0;
    logic        cur_zf = 1'b0;

    function automatic logic [15:0] m(input int b);
        return 16'(1) << b;
    endfunction

    task automatic build_table();
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 8; s++) ucode[o][s] = '0;
            ucode[o][0] = m(BCo) | m(BMi);
            ucode[o][1] = m(BRo) | m(BIi) | m(BCe);
            last_step[o] = 1;
        end
        ucode[1][2] = m(BIo) | m(BMi);  ucode[1][3] = m(BRo) | m(BAi);  last_step[1] = 3;
        for (int o = 2; o <= 3; o++) begin
            ucode[o][2] = m(BIo) | m(BMi);
            ucode[o][3] = m(BRo) | m(BBi);
            ucode[o][4] = m(BEo) | m(BAi) | m(BFin);
            last_step[o] = 4;
        end
        ucode[3][4] |= m(BSu);
        ucode[4][2] = m(BIo) | m(BMi);  ucode[4][3] = m(BAo) | m(BRi);  last_step[4] = 3;
        ucode[5][2] = m(BIo) | m(BAi);  last_step[5] = 2;
        ucode[6][2] = m(BIo) | m(BJ);   last_step[6] = 2;
        ucode[7][2] = m(BIo);           last_step[7] = 2;
        ucode[8][2] = m(BIo);           last_step[8] = 2;
        ucode[14][2] = m(BAo) | m(BOi); last_step[14] = 2;
        ucode[15][2] = m(BHlt);         last_step[15] = 2;
    endtask

    // Model state after a rising edge with the given inputs held across it
    task automatic model_edge();
        if (!cur_rst) begin
            mstep = 0;
            mhalt = 1'b0;
        end else if (!mhalt) begin
            if (mstep == 2 && cur_op == 4'hF) mhalt = 1'b1;
            else if (mstep == int'(NSTEPS) - 1 || (Early && mstep == last_step[cur_op])) mstep = 0;
            else mstep = mstep + 1;
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] op, input logic cf, input logic zf);
        exp_t e;
        logic [15:0] act;
        RESETn = r;  bus.OPCODE = op;  bus.CF = cf;  bus.ZF = zf;
        cur_rst = r; cur_op = op;      cur_cf = cf;  cur_zf = zf;
        act = '0;
        e.step = 3'd0;
        if (r) begin
            e.step = 3'(mstep);
            if (mhalt) act = m(BHlt);
            else begin
                act = ucode[op][mstep];
                if (mstep == 2 && ((op == 4'h7 && cf) || (op == 4'h8 && zf))) act |= m(BJ);
            end
        end
        e.ctrl = act ^ m(BFin);
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [3:0] op, input logic cf, input logic zf);
        @(posedge CLK);
        #1;
        model_edge();
        drive(r, op, cf, zf);
    endtask

    // Run one instruction from T0 until the model would wrap (bounded for HLT)
    task automatic instr(input logic [3:0] op, input logic cf, input logic zf);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, op, cf, zf);
            if (mhalt || mstep == int'(NSTEPS) - 1 || (Early && mstep == last_step[op])) break;
        end
    endtask

    // Monitor: every cycle the DUT presents a control word, compare at the falling edge
    initial begin : monitor
        exp_t        e;
        logic [15:0] got;
        while (!done) begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                got = {bus.HLT, bus.MI, bus.RI, bus.RO, bus.II, bus.IO, bus.AI, bus.AO,
                       bus.EO, bus.SU, bus.FIn, bus.BI, bus.OI, bus.CE, bus.CO, bus.J};
                total++;
                if (got !== e.ctrl) begin
                    bad++;
                    $display("FAIL ctrl t=%0t step=%0d op=%h got=%b want=%b",
                             $time, e.step, cur_op, got, e.ctrl);
                end
                total++;
                if (bus.STEP !== e.step) begin
                    bad++;
                    $display("FAIL step t=%0t got=%0d want=%0d", $time, bus.STEP, e.step);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] rop;
        int         hcnt;
        build_table();
        RESETn = 1'b0;
        bus.OPCODE = 4'h0;
        bus.CF = 1'b0;
        bus.ZF = 1'b0;

        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'h0, 1'b0, 1'b0);
        while (mstep != int'(NSTEPS) - 1) cyc(1'b1, 4'h0, 1'b0, 1'b0);

        instr(4'h3, 1'b0, 1'b0);
        instr(4'h2, 1'b1, 1'b1);
        instr(4'h7, 1'b1, 1'b0);
        instr(4'h7, 1'b0, 1'b1);
        instr(4'h8, 1'b0, 1'b1);
        instr(4'h8, 1'b1, 1'b0);
        instr(4'h1, 1'b0, 1'b0);
        instr(4'h4, 1'b0, 1'b0);
        instr(4'h5, 1'b0, 1'b0);
        instr(4'h6, 1'b0, 1'b0);
        instr(4'hE, 1'b0, 1'b0);
        instr(4'hA, 1'b1, 1'b1);

        // Reset during T3 of LDA
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b0, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        while (mstep != int'(NSTEPS) - 1) cyc(1'b1, 4'h0, 1'b0, 1'b0);

        instr(4'h5, 1'b0, 1'b0);
        instr(4'h7, 1'b0, 1'b0);
        instr(4'h0, 1'b0, 1'b0);

        // Halt, hold, then reset out of it
        instr(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'hF, 1'b1, 1'b1);
        cyc(1'b0, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);

        rop = 4'h0;
        hcnt = 0;
        for (int i = 0; i < 800; i++) begin
            logic r;
            @(posedge CLK);
            #1;
            model_edge();
            if (mstep == 0) begin
                rop = 4'($urandom_range(0, 15));
                if (rop == 4'hF && $urandom_range(0, 3) != 0) rop = 4'h2;
            end
            hcnt = mhalt ? hcnt + 1 : 0;
            r = ($urandom_range(0, 49) != 0) && (hcnt < 6);
            drive(r, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        @(negedge CLK);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
